// File: rtl/player_motion_pkg.sv
// Shared types and default tuning constants for the player kinematics block.
package player_motion_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        AIR    = 2'd1,
        STUN   = 2'd2
    } player_state_e;

    localparam int DEF_XW        = 11;
    localparam int DEF_YW        = 10;
    localparam int DEF_X_MIN     = -300;
    localparam int DEF_X_MAX     = 300;
    localparam int DEF_Y_GROUND  = -200;
    localparam int DEF_Y_SQUAT   = -220;
    localparam int DEF_Y_MAX     = 200;
    localparam int DEF_STEP_X    = 4;
    localparam int DEF_V0        = 12;
    localparam int DEF_G         = 1;
    localparam int DEF_AIR_JUMPS = 1;
    localparam int DEF_KB_FRAMES = 8;
    localparam int DEF_KB_STEP   = 6;

    // Bits needed to hold 0..n; never returns zero so counters stay legal
    // when the configured count is 0.
    function automatic int count_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/player_vert_phys.sv
// Combinational vertical integrator: one tick of y/vy motion with optional
// mid-air boost, velocity floor, ceiling clamp and ground landing.
module player_vert_phys
    import player_motion_pkg::*;
#(
    parameter int YW       = DEF_YW,
    parameter int Y_GROUND = DEF_Y_GROUND,
    parameter int Y_MAX    = DEF_Y_MAX,
    parameter int V0       = DEF_V0,
    parameter int G        = DEF_G
) (
    input  logic signed [YW-1:0] y,
    input  logic signed [YW-1:0] vy,
    input  logic                 boost,
    output logic signed [YW-1:0] y_next,
    output logic signed [YW-1:0] vy_next,
    output logic                 landed
);

    localparam logic signed [YW:0]   Y_GROUND_W = (YW+1)'(Y_GROUND);
    localparam logic signed [YW:0]   Y_MAX_W    = (YW+1)'(Y_MAX);
    localparam logic signed [YW:0]   V0_W       = (YW+1)'(V0);
    localparam logic signed [YW:0]   G_W        = (YW+1)'(G);
    localparam logic signed [YW:0]   VY_FLOOR_W = (YW+1)'(1 - 2**(YW-1));
    localparam logic signed [YW-1:0] Y_GROUND_N = YW'(Y_GROUND);
    localparam logic signed [YW-1:0] Y_MAX_N    = YW'(Y_MAX);

    logic signed [YW:0] y_ext;
    logic signed [YW:0] vy_ext;
    logic signed [YW:0] y_sum;
    logic signed [YW:0] vy_raw;
    logic signed [YW:0] vy_sat;

    // Integrate in one extra bit, then resolve landing first and the ceiling second.
    always_comb begin
        y_ext  = {y[YW-1], y};
        vy_ext = {vy[YW-1], vy};
        if (boost) begin
            y_sum  = y_ext + V0_W;
            vy_raw = V0_W - G_W;
        end else begin
            y_sum  = y_ext + vy_ext;
            vy_raw = vy_ext - G_W;
        end
        vy_sat  = (vy_raw < VY_FLOOR_W) ? VY_FLOOR_W : vy_raw;
        landed  = 1'b0;
        y_next  = y_sum[YW-1:0];
        vy_next = vy_sat[YW-1:0];
        if (y_sum <= Y_GROUND_W) begin
            y_next  = Y_GROUND_N;
            vy_next = '0;
            landed  = 1'b1;
        end else if (y_sum >= Y_MAX_W) begin
            y_next = Y_MAX_N;
            if (!vy_sat[YW]) begin
                vy_next = '0;
            end
        end
    end

endmodule

// File: rtl/player_motion.sv
// Frame-tick player kinematics: walking, multi-jump, defend-gated knockback
// with hitstun. All outputs are registered and advance only on tick.
module player_motion
    import player_motion_pkg::*;
#(
    parameter int XW        = DEF_XW,
    parameter int YW        = DEF_YW,
    parameter int X_MIN     = DEF_X_MIN,
    parameter int X_MAX     = DEF_X_MAX,
    parameter int Y_GROUND  = DEF_Y_GROUND,
    parameter int Y_SQUAT   = DEF_Y_SQUAT,
    parameter int Y_MAX     = DEF_Y_MAX,
    parameter int STEP_X    = DEF_STEP_X,
    parameter int V0        = DEF_V0,
    parameter int G         = DEF_G,
    parameter int AIR_JUMPS = DEF_AIR_JUMPS,
    parameter int KB_FRAMES = DEF_KB_FRAMES,
    parameter int KB_STEP   = DEF_KB_STEP
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 right,
    input  logic                 left,
    input  logic                 jump,
    input  logic                 squat,
    input  logic                 defend,
    input  logic                 hit,
    input  logic                 hit_dir,
    output logic signed [XW-1:0] x,
    output logic signed [YW-1:0] y,
    output logic signed [YW-1:0] vy,
    output player_state_e        state,
    output logic                 isD,
    output logic                 isQ,
    output logic                 isJ,
    output logic                 isK
);

    localparam int AW = count_width(AIR_JUMPS);
    localparam int SW = count_width(KB_FRAMES);

    localparam logic signed [XW:0]   X_MIN_W     = (XW+1)'(X_MIN);
    localparam logic signed [XW:0]   X_MAX_W     = (XW+1)'(X_MAX);
    localparam logic signed [XW:0]   STEP_W      = (XW+1)'(STEP_X);
    localparam logic signed [XW:0]   KB_W        = (XW+1)'(KB_STEP);
    localparam logic signed [XW-1:0] X_MIN_N     = XW'(X_MIN);
    localparam logic signed [YW:0]   Y_GROUND_W  = (YW+1)'(Y_GROUND);
    localparam logic signed [YW:0]   Y_MAX_W     = (YW+1)'(Y_MAX);
    localparam logic signed [YW:0]   V0_W        = (YW+1)'(V0);
    localparam logic signed [YW-1:0] Y_GROUND_N  = YW'(Y_GROUND);
    localparam logic signed [YW-1:0] Y_SQUAT_N   = YW'(Y_SQUAT);
    localparam logic signed [YW-1:0] Y_MAX_N     = YW'(Y_MAX);
    localparam logic signed [YW-1:0] VY_TAKEOFF  = YW'(V0 - G);
    localparam logic [AW-1:0]        AIR_JUMPS_N = AW'(AIR_JUMPS);
    localparam logic [SW-1:0]        KB_FRAMES_N = SW'(KB_FRAMES);
    localparam logic [SW-1:0]        STUN_LAST   = SW'(1);

    logic                 jump_prev;
    logic                 airborne;
    logic                 kb_dir;
    logic [AW-1:0]        air_cnt;
    logic [SW-1:0]        stun_cnt;

    logic                 jump_ev;
    logic                 hit_taken;
    logic                 air_jump_ok;
    logic                 stun_airborne;
    logic signed [XW:0]   x_ext;
    logic signed [XW-1:0] walk_x;
    logic signed [XW-1:0] kb_x;
    logic signed [YW:0]   takeoff_sum;
    logic signed [YW-1:0] takeoff_y;
    logic signed [YW-1:0] y_phys;
    logic signed [YW-1:0] vy_phys;
    logic                 landed;

    function automatic logic signed [XW-1:0] clamp_x(input logic signed [XW:0] v);
        if (v < X_MIN_W) return X_MIN_W[XW-1:0];
        if (v > X_MAX_W) return X_MAX_W[XW-1:0];
        return v[XW-1:0];
    endfunction

    // A hit outranks everything, so it also cancels any mid-air jump on that tick.
    assign jump_ev       = jump & ~jump_prev;
    assign hit_taken     = hit & ~(defend & (state == GROUND)) & (state != STUN);
    assign air_jump_ok   = jump_ev & (state == AIR) & (air_cnt < AIR_JUMPS_N) & ~hit_taken;
    assign stun_airborne = airborne & ~landed;

    // Candidate horizontal positions and the clamped ground takeoff height.
    always_comb begin
        x_ext  = {x[XW-1], x};
        walk_x = x;
        if (right) begin
            walk_x = clamp_x(x_ext + STEP_W);
        end else if (left) begin
            walk_x = clamp_x(x_ext - STEP_W);
        end
        kb_x = kb_dir ? clamp_x(x_ext + KB_W) : clamp_x(x_ext - KB_W);

        takeoff_sum = {y[YW-1], y} + V0_W;
        takeoff_y   = takeoff_sum[YW-1:0];
        if (takeoff_sum < Y_GROUND_W) begin
            takeoff_y = Y_GROUND_N;
        end else if (takeoff_sum > Y_MAX_W) begin
            takeoff_y = Y_MAX_N;
        end
    end

    player_vert_phys #(
        .YW       (YW),
        .Y_GROUND (Y_GROUND),
        .Y_MAX    (Y_MAX),
        .V0       (V0),
        .G        (G)
    ) u_vert_phys (
        .y       (y),
        .vy      (vy),
        .boost   (air_jump_ok),
        .y_next  (y_phys),
        .vy_next (vy_phys),
        .landed  (landed)
    );

    // Player FSM with registered pose flags; isD/isQ only assert while the player stays grounded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= X_MIN_N;
            y         <= Y_GROUND_N;
            vy        <= '0;
            state     <= GROUND;
            isD       <= 1'b0;
            isQ       <= 1'b0;
            isJ       <= 1'b0;
            isK       <= 1'b0;
            air_cnt   <= '0;
            stun_cnt  <= '0;
            jump_prev <= 1'b0;
            airborne  <= 1'b0;
            kb_dir    <= 1'b0;
        end else if (tick) begin
            jump_prev <= jump;
            isD       <= 1'b0;
            isQ       <= 1'b0;
            if (hit_taken) begin
                state    <= STUN;
                stun_cnt <= KB_FRAMES_N;
                kb_dir   <= hit_dir;
                isK      <= 1'b1;
                if (state == AIR) begin
                    y        <= y_phys;
                    vy       <= vy_phys;
                    airborne <= ~landed;
                    isJ      <= ~landed;
                end else begin
                    y        <= Y_GROUND_N;
                    vy       <= '0;
                    airborne <= 1'b0;
                    isJ      <= 1'b0;
                end
            end else begin
                case (state)
                    GROUND: begin
                        isJ <= 1'b0;
                        isK <= 1'b0;
                        vy  <= '0;
                        if (jump_ev) begin
                            y        <= takeoff_y;
                            vy       <= VY_TAKEOFF;
                            state    <= AIR;
                            air_cnt  <= '0;
                            airborne <= 1'b1;
                            isJ      <= 1'b1;
                        end else if (squat) begin
                            y   <= Y_SQUAT_N;
                            isQ <= ~defend;
                            isD <= defend;
                        end else if (defend) begin
                            y   <= Y_GROUND_N;
                            isD <= 1'b1;
                        end else begin
                            x <= walk_x;
                            y <= Y_GROUND_N;
                        end
                    end
                    AIR: begin
                        x  <= walk_x;
                        y  <= y_phys;
                        vy <= vy_phys;
                        if (air_jump_ok) begin
                            air_cnt <= air_cnt + 1'b1;
                        end
                        if (landed) begin
                            state    <= GROUND;
                            airborne <= 1'b0;
                            isJ      <= 1'b0;
                        end
                    end
                    STUN: begin
                        x        <= kb_x;
                        y        <= y_phys;
                        vy       <= vy_phys;
                        airborne <= stun_airborne;
                        isJ      <= stun_airborne;
                        stun_cnt <= stun_cnt - 1'b1;
                        if (stun_cnt == STUN_LAST) begin
                            state <= stun_airborne ? AIR : GROUND;
                            isK   <= 1'b0;
                        end
                    end
                    default: begin
                        state <= GROUND;
                    end
                endcase
            end
        end
    end

endmodule
